// File: rtl/mem_stage_axs.sv
// mem_stage_axs: pipeline memory stage. Forwards EX results to WB, runs one
// data-bus transaction per load/store with byte-lane steering, load
// extension and a WAIT timeout.
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned halfword/word
// accesses. Without it the low address bits of such accesses are forced to 0.
module mem_stage_axs #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned REG_ADDR_W  = 5,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   input  logic [REG_ADDR_W-1:0] wd_i,
   input  logic                  wreg_i,
   input  logic [31:0]           wdata_i,
   input  logic [3:0]            mem_op_i,
   input  logic [ADDR_W-1:0]     mem_addr_i,
   input  logic [31:0]           mem_sdata_i,
   output logic                  d_req_o,
   output logic                  d_we_o,
   output logic [ADDR_W-1:0]     d_addr_o,
   output logic [3:0]            d_sel_o,
   output logic [31:0]           d_wdata_o,
   input  logic [31:0]           d_rdata_i,
   input  logic                  d_ack_i,
   output logic                  stallreq_o,
   output logic                  valid_o,
   output logic                  wreg_o,
   output logic [REG_ADDR_W-1:0] wd_o,
   output logic [31:0]           wdata_o,
   output logic                  bus_err_o,
   output logic                  align_exc_o
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

   localparam logic [3:0] OP_LB  = 4'h1;
   localparam logic [3:0] OP_LBU = 4'h2;
   localparam logic [3:0] OP_LH  = 4'h3;
   localparam logic [3:0] OP_LHU = 4'h4;
   localparam logic [3:0] OP_LW  = 4'h5;
   localparam logic [3:0] OP_SB  = 4'h6;
   localparam logic [3:0] OP_SH  = 4'h7;
   localparam logic [3:0] OP_SW  = 4'h8;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [3:0]            op_q, op_d;
   logic [1:0]            lane_q, lane_d;
   logic [REG_ADDR_W-1:0] wd_lat_q, wd_lat_d;
   logic                  wreg_lat_q, wreg_lat_d;
   logic [DATA_W-1:0]     wdata_lat_q, wdata_lat_d;

   logic                  d_req_q, d_req_d;
   logic                  d_we_q, d_we_d;
   logic [ADDR_W-1:0]     d_addr_q, d_addr_d;
   logic [3:0]            d_sel_q, d_sel_d;
   logic [DATA_W-1:0]     d_wdata_q, d_wdata_d;
   logic                  valid_q, valid_d;
   logic                  wreg_q, wreg_d;
   logic [REG_ADDR_W-1:0] wd_q, wd_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic                  bus_err_q, bus_err_d;
   logic                  align_exc_q, align_exc_d;
   logic                  stall_c;

   logic                  in_load, in_store, in_half, in_word, in_mem;
   logic                  align_fault_c;
   logic [1:0]            lane_c;
   logic [ADDR_W-1:0]     eff_addr_c;
   logic [3:0]            sel_c;
   logic [DATA_W-1:0]     bdata_c;
   logic [7:0]            ld_byte_c;
   logic [15:0]           ld_half_c;
   logic [DATA_W-1:0]     ld_data_c;
   logic                  lat_is_load;
   logic                  timeout_c;

   // Decode the incoming memory opcode; unknown codes behave as none.
   always_comb begin
      in_load  = 1'b0;
      in_store = 1'b0;
      in_half  = 1'b0;
      in_word  = 1'b0;
      case (mem_op_i)
         OP_LB, OP_LBU: in_load = 1'b1;
         OP_LH, OP_LHU: begin in_load = 1'b1; in_half = 1'b1; end
         OP_LW:         begin in_load = 1'b1; in_word = 1'b1; end
         OP_SB:         in_store = 1'b1;
         OP_SH:         begin in_store = 1'b1; in_half = 1'b1; end
         OP_SW:         begin in_store = 1'b1; in_word = 1'b1; end
         default:       ;
      endcase
   end

   assign in_mem = in_load | in_store;

`ifdef MEM_ALIGN_CHECK_EN
   assign align_fault_c = in_mem & ((in_half & mem_addr_i[0]) | (in_word & (|mem_addr_i[1:0])));
`else
   assign align_fault_c = 1'b0;
`endif

   // Effective lane (misaligned low bits dropped), byte enables and store data.
   always_comb begin
      if (in_word)      lane_c = 2'b00;
      else if (in_half) lane_c = {mem_addr_i[1], 1'b0};
      else              lane_c = mem_addr_i[1:0];
      eff_addr_c = {mem_addr_i[ADDR_W-1:2], lane_c};
      if (in_word)      sel_c = 4'b1111;
      else if (in_half) sel_c = lane_c[1] ? 4'b1100 : 4'b0011;
      else              sel_c = 4'b0001 << lane_c;
      if (in_word)      bdata_c = mem_sdata_i;
      else if (in_half) bdata_c = {2{mem_sdata_i[15:0]}};
      else              bdata_c = {4{mem_sdata_i[7:0]}};
   end

   // Extract and extend load data using the latched opcode and lane.
   always_comb begin
      case (lane_q)
         2'd0:    ld_byte_c = d_rdata_i[7:0];
         2'd1:    ld_byte_c = d_rdata_i[15:8];
         2'd2:    ld_byte_c = d_rdata_i[23:16];
         default: ld_byte_c = d_rdata_i[31:24];
      endcase
      ld_half_c = lane_q[1] ? d_rdata_i[31:16] : d_rdata_i[15:0];
      case (op_q)
         OP_LB:   ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
         OP_LBU:  ld_data_c = {24'd0, ld_byte_c};
         OP_LH:   ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
         OP_LHU:  ld_data_c = {16'd0, ld_half_c};
         default: ld_data_c = d_rdata_i;
      endcase
   end

   assign lat_is_load = (op_q >= OP_LB) && (op_q <= OP_LW);
   assign timeout_c   = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic; ack takes priority over timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (valid_i && in_mem && !align_fault_c) state_d = S_WAIT;
         S_WAIT:  if (d_ack_i || timeout_c) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output/datapath next values and the combinational stall request.
   always_comb begin
      cnt_d       = cnt_q;
      op_d        = op_q;
      lane_d      = lane_q;
      wd_lat_d    = wd_lat_q;
      wreg_lat_d  = wreg_lat_q;
      wdata_lat_d = wdata_lat_q;
      d_req_d     = d_req_q;
      d_we_d      = d_we_q;
      d_addr_d    = d_addr_q;
      d_sel_d     = d_sel_q;
      d_wdata_d   = d_wdata_q;
      valid_d     = 1'b0;
      wreg_d      = 1'b0;
      wd_d        = wd_q;
      wdata_d     = wdata_q;
      bus_err_d   = 1'b0;
      align_exc_d = 1'b0;
      stall_c     = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (valid_i) begin
               if (align_fault_c) begin
                  valid_d     = 1'b1;
                  wd_d        = wd_i;
                  align_exc_d = 1'b1;
               end else if (in_mem) begin
                  stall_c     = 1'b1;
                  d_req_d     = 1'b1;
                  d_we_d      = in_store;
                  d_addr_d    = eff_addr_c;
                  d_sel_d     = sel_c;
                  d_wdata_d   = bdata_c;
                  op_d        = mem_op_i;
                  lane_d      = lane_c;
                  wd_lat_d    = wd_i;
                  wreg_lat_d  = wreg_i & in_load;
                  wdata_lat_d = wdata_i;
               end else begin
                  valid_d = 1'b1;
                  wreg_d  = wreg_i;
                  wd_d    = wd_i;
                  wdata_d = wdata_i;
               end
            end
         end
         S_WAIT: begin
            if (d_ack_i) begin
               d_req_d = 1'b0;
               d_we_d  = 1'b0;
               valid_d = 1'b1;
               wreg_d  = wreg_lat_q;
               wd_d    = wd_lat_q;
               wdata_d = lat_is_load ? ld_data_c : wdata_lat_q;
            end else if (timeout_c) begin
               // The instruction retires with an error, so upstream may advance.
               d_req_d   = 1'b0;
               d_we_d    = 1'b0;
               valid_d   = 1'b1;
               wd_d      = wd_lat_q;
               bus_err_d = 1'b1;
            end else begin
               stall_c = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q       <= '0;
         op_q        <= '0;
         lane_q      <= '0;
         wd_lat_q    <= '0;
         wreg_lat_q  <= 1'b0;
         wdata_lat_q <= '0;
         d_req_q     <= 1'b0;
         d_we_q      <= 1'b0;
         d_addr_q    <= '0;
         d_sel_q     <= '0;
         d_wdata_q   <= '0;
         valid_q     <= 1'b0;
         wreg_q      <= 1'b0;
         wd_q        <= '0;
         wdata_q     <= '0;
         bus_err_q   <= 1'b0;
         align_exc_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         lane_q      <= lane_d;
         wd_lat_q    <= wd_lat_d;
         wreg_lat_q  <= wreg_lat_d;
         wdata_lat_q <= wdata_lat_d;
         d_req_q     <= d_req_d;
         d_we_q      <= d_we_d;
         d_addr_q    <= d_addr_d;
         d_sel_q     <= d_sel_d;
         d_wdata_q   <= d_wdata_d;
         valid_q     <= valid_d;
         wreg_q      <= wreg_d;
         wd_q        <= wd_d;
         wdata_q     <= wdata_d;
         bus_err_q   <= bus_err_d;
         align_exc_q <= align_exc_d;
      end
   end

   assign stallreq_o  = rst & stall_c;
   assign d_req_o     = d_req_q;
   assign d_we_o      = d_we_q;
   assign d_addr_o    = d_addr_q;
   assign d_sel_o     = d_sel_q;
   assign d_wdata_o   = d_wdata_q;
   assign valid_o     = valid_q;
   assign wreg_o      = wreg_q;
   assign wd_o        = wd_q;
   assign wdata_o     = wdata_q;
   assign bus_err_o   = bus_err_q;
   assign align_exc_o = align_exc_q;

endmodule

// File: tb/tb_mem_stage_axs.sv
// tb_mem_stage_axs: directed stimulus with a result scoreboard for mem_stage_axs.
// Honours MEM_ALIGN_CHECK_EN the same way the design does.
module tb_mem_stage_axs;

   typedef struct packed {
      logic        wreg;
      logic [4:0]  wd;
      logic [31:0] wdata;
      logic        berr;
      logic        aexc;
   } exp_t;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] eaddr;
      logic [31:0] sdata;
      logic [31:0] rdata;
      logic [31:0] wdin;
      logic [4:0]  wd;
      logic        wreg;
      logic [7:0]  ack_wait;
      logic [3:0]  sel;
      logic [31:0] bdata;
      logic [31:0] out;
      logic        owreg;
   } vec_t;

   logic        clk, rst;
   logic        valid_i, wreg_i, d_ack_i;
   logic [4:0]  wd_i;
   logic [31:0] wdata_i, mem_addr_i, mem_sdata_i, d_rdata_i;
   logic [3:0]  mem_op_i;
   logic        d_req_o, d_we_o, stallreq_o, valid_o, wreg_o, bus_err_o, align_exc_o;
   logic [31:0] d_addr_o, d_wdata_o, wdata_o;
   logic [3:0]  d_sel_o;
   logic [4:0]  wd_o;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   vec_t vecs[8];

   mem_stage_axs #(.ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT_CYC(4)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
      .wdata_i(wdata_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
      .mem_sdata_i(mem_sdata_i), .d_req_o(d_req_o), .d_we_o(d_we_o),
      .d_addr_o(d_addr_o), .d_sel_o(d_sel_o), .d_wdata_o(d_wdata_o),
      .d_rdata_i(d_rdata_i), .d_ack_i(d_ack_i), .stallreq_o(stallreq_o),
      .valid_o(valid_o), .wreg_o(wreg_o), .wd_o(wd_o), .wdata_o(wdata_o),
      .bus_err_o(bus_err_o), .align_exc_o(align_exc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic wr, input logic [4:0] wd, input logic [31:0] wdat,
                           input logic be, input logic ae);
      exp_t e;
      e.wreg = wr; e.wd = wd; e.wdata = wdat; e.berr = be; e.aexc = ae;
      exp_q.push_back(e);
   endtask

   function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] eaddr,
                               input logic [31:0] sdata, input logic [31:0] rdata,
                               input logic [31:0] wdin, input logic [4:0] wd, input logic wreg,
                               input logic [7:0] ackw, input logic [3:0] sel,
                               input logic [31:0] bdata, input logic [31:0] out, input logic owreg);
      vec_t v;
      v.op = op; v.addr = addr; v.eaddr = eaddr; v.sdata = sdata; v.rdata = rdata;
      v.wdin = wdin; v.wd = wd; v.wreg = wreg; v.ack_wait = ackw; v.sel = sel;
      v.bdata = bdata; v.out = out; v.owreg = owreg;
      return v;
   endfunction

   // Monitor: every presented result is matched against the scoreboard head.
   always @(negedge clk) begin
      if (rst) begin
         if (valid_o) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", 32'(valid_o), 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("res_wreg",  32'(wreg_o),      32'(mon_e.wreg));
               chk("res_wd",    32'(wd_o),        32'(mon_e.wd));
               chk("res_wdata", wdata_o,          mon_e.wdata);
               chk("res_berr",  32'(bus_err_o),   32'(mon_e.berr));
               chk("res_aexc",  32'(align_exc_o), 32'(mon_e.aexc));
            end
         end else if (bus_err_o || align_exc_o) begin
            chk("err_without_valid", {30'd0, bus_err_o, align_exc_o}, 32'd0);
         end
      end
   end

   // Issue one load/store, acking after ack_wait stalled WAIT cycles.
   task automatic do_txn(input vec_t v, input string nm);
      int          stalls;
      logic        req_s, we_s;
      logic [3:0]  sel_s;
      logic [31:0] addr_s, bd_s;
      push_exp(v.owreg, v.wd, v.out, 1'b0, 1'b0);
      valid_i = 1'b1; mem_op_i = v.op; mem_addr_i = v.addr; mem_sdata_i = v.sdata;
      wd_i = v.wd; wreg_i = v.wreg; wdata_i = v.wdin;
      stalls = 0;
      @(negedge clk); if (stallreq_o) stalls++;
      @(posedge clk); #1;
      req_s = d_req_o; we_s = d_we_o; sel_s = d_sel_o; addr_s = d_addr_o; bd_s = d_wdata_o;
      for (int i = 0; i < int'(v.ack_wait); i++) begin
         @(negedge clk); if (stallreq_o) stalls++;
         @(posedge clk); #1;
      end
      d_ack_i = 1'b1; d_rdata_i = v.rdata;
      @(negedge clk); if (stallreq_o) stalls++;
      @(posedge clk); #1;
      d_ack_i = 1'b0; d_rdata_i = 32'd0; valid_i = 1'b0;
      chk({nm, "_req"},   32'(req_s), 32'd1);
      chk({nm, "_we"},    32'(we_s),  32'(v.op >= 4'd6));
      chk({nm, "_sel"},   32'(sel_s), 32'(v.sel));
      chk({nm, "_addr"},  addr_s,     v.eaddr);
      if (v.op >= 4'd6) chk({nm, "_bdata"}, bd_s, v.bdata);
      chk({nm, "_stall"}, 32'(stalls), 32'(v.ack_wait) + 32'd1);
      chk({nm, "_req_drop"}, 32'(d_req_o), 32'd0);
   endtask

   initial begin
      int   req_cnt, vcnt;
      logic done;
      rst = 1'b0; valid_i = 1'b1; mem_op_i = 4'h5; mem_addr_i = 32'h100; mem_sdata_i = 32'd0;
      wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'd0; d_rdata_i = 32'd0; d_ack_i = 1'b1;

      vecs[0] = mk(4'h1, 32'h103, 32'h103, 32'h0,        32'h80FFFFFF, 32'h0,        5'd5,  1'b1, 8'd2, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b1);
      vecs[1] = mk(4'h7, 32'h202, 32'h202, 32'h0000BEEF, 32'h0,        32'hCAFE0000, 5'd7,  1'b0, 8'd0, 4'b1100, 32'hBEEFBEEF, 32'hCAFE0000, 1'b0);
      vecs[2] = mk(4'h2, 32'h101, 32'h101, 32'h0,        32'h1234F600, 32'h0,        5'd8,  1'b1, 8'd1, 4'b0010, 32'h0,        32'h000000F6, 1'b1);
      vecs[3] = mk(4'h3, 32'h102, 32'h102, 32'h0,        32'h80017FFF, 32'h0,        5'd10, 1'b1, 8'd0, 4'b1100, 32'h0,        32'hFFFF8001, 1'b1);
      vecs[4] = mk(4'h4, 32'h100, 32'h100, 32'h0,        32'h80017FFF, 32'h0,        5'd11, 1'b1, 8'd0, 4'b0011, 32'h0,        32'h00007FFF, 1'b1);
      vecs[5] = mk(4'h6, 32'h001, 32'h001, 32'h000000AB, 32'h0,        32'h11111111, 5'd12, 1'b1, 8'd0, 4'b0010, 32'hABABABAB, 32'h11111111, 1'b0);
      vecs[6] = mk(4'h8, 32'h3FC, 32'h3FC, 32'hDEADBEEF, 32'h0,        32'h00000022, 5'd13, 1'b0, 8'd0, 4'b1111, 32'hDEADBEEF, 32'h00000022, 1'b0);
      // Ack lands in the same cycle the counter expires: ack must win.
      vecs[7] = mk(4'h5, 32'h200, 32'h200, 32'h0,        32'h13579BDF, 32'h0,        5'd14, 1'b1, 8'd3, 4'b1111, 32'h0,        32'h13579BDF, 1'b1);

      // Reset state, with a pending memory op and ack on the inputs.
      #12;
      chk("rst_d_req",   32'(d_req_o),    32'd0);
      chk("rst_stall",   32'(stallreq_o), 32'd0);
      chk("rst_valid",   32'(valid_o),    32'd0);
      chk("rst_sel",     32'(d_sel_o),    32'd0);
      chk("rst_wdata",   wdata_o,         32'd0);
      chk("rst_addr",    d_addr_o,        32'd0);
      valid_i = 1'b0; d_ack_i = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      // Pass-through of a non-memory result.
      push_exp(1'b1, 5'd3, 32'h12345678, 1'b0, 1'b0);
      valid_i = 1'b1; mem_op_i = 4'h0; wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h12345678;
      @(negedge clk); chk("none_stall", 32'(stallreq_o), 32'd0);
      @(posedge clk); #1; valid_i = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("bubble_valid", 32'(valid_o), 32'd0);
      chk("bubble_wd",    32'(wd_o),    32'd3);
      chk("bubble_wdata", wdata_o,      32'h12345678);
      @(posedge clk); #1;

      // Ack outside WAIT is ignored.
      d_ack_i = 1'b1; vcnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); if (valid_o || d_req_o) vcnt++;
         @(posedge clk); #1;
      end
      d_ack_i = 1'b0;
      chk("idle_ack_ignored", 32'(vcnt), 32'd0);

      // Directed loads and stores.
      for (int i = 0; i < 8; i++) do_txn(vecs[i], $sformatf("txn%0d", i));

      // Timeout with no ack.
      push_exp(1'b0, 5'd9, 32'h13579BDF, 1'b1, 1'b0);
      valid_i = 1'b1; mem_op_i = 4'h5; mem_addr_i = 32'h100; wd_i = 5'd9; wreg_i = 1'b1;
      req_cnt = 0; done = 1'b0;
      for (int i = 0; i < 12 && !done; i++) begin
         @(negedge clk);
         if (d_req_o) req_cnt++;
         if (!stallreq_o) done = 1'b1;
         @(posedge clk); #1;
      end
      valid_i = 1'b0;
      chk("tmo_done",      32'(done),    32'd1);
      chk("tmo_req_cycles", 32'(req_cnt), 32'd4);
      chk("tmo_req_drop",  32'(d_req_o), 32'd0);
      @(posedge clk); #1;
      chk("tmo_berr_pulse", 32'(bus_err_o), 32'd0);

      // Misaligned word access.
`ifdef MEM_ALIGN_CHECK_EN
      push_exp(1'b0, 5'd4, 32'h13579BDF, 1'b0, 1'b1);
      valid_i = 1'b1; mem_op_i = 4'h5; mem_addr_i = 32'h101; wd_i = 5'd4; wreg_i = 1'b1;
      @(negedge clk); chk("align_stall", 32'(stallreq_o), 32'd0);
      @(posedge clk); #1; valid_i = 1'b0;
      chk("align_no_req", 32'(d_req_o),     32'd0);
      chk("align_exc",    32'(align_exc_o), 32'd1);
      @(posedge clk); #1;
      chk("align_pulse",  32'(align_exc_o), 32'd0);
      chk("align_no_req2", 32'(d_req_o),    32'd0);
`else
      do_txn(mk(4'h5, 32'h101, 32'h100, 32'h0, 32'hA5A51234, 32'h0, 5'd4, 1'b1, 8'd0,
                4'b1111, 32'h0, 32'hA5A51234, 1'b1), "misalign_lw");
      chk("align_exc_tied", 32'(align_exc_o), 32'd0);
`endif

      // Reset asserted mid-transaction abandons it.
      valid_i = 1'b1; mem_op_i = 4'h5; mem_addr_i = 32'h300; wd_i = 5'd15; wreg_i = 1'b1;
      @(posedge clk); #1;
      chk("rstw_req_before", 32'(d_req_o), 32'd1);
      #2 rst = 1'b0; valid_i = 1'b0;
      #1;
      chk("rstw_req_now", 32'(d_req_o),    32'd0);
      chk("rstw_stall",   32'(stallreq_o), 32'd0);
      @(negedge clk); rst = 1'b1;
      vcnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1; if (valid_o || d_req_o) vcnt++;
      end
      chk("rstw_no_valid", 32'(vcnt), 32'd0);

      @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_axs.md
MEM_STAGE_AXS -- requirements
Module: mem_stage_axs

Interface
REQ-001 The module SHALL take parameter ADDR_W, default 32, meaning the data-bus address width.
REQ-002 The module SHALL take parameter REG_ADDR_W, default 5, meaning the destination register index width.
REQ-003 The module SHALL take parameter TIMEOUT_CYC, default 255, meaning the maximum number of WAIT cycles before a bus abort.
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 The module SHALL have port rst, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-006 The module SHALL have port valid_i, input, 1 bit, meaning an EX result is present.
REQ-007 The module SHALL have ports wd_i (input, REG_ADDR_W), wreg_i (input, 1) and wdata_i (input, 32), the EX destination index, write enable and result.
REQ-008 The module SHALL have port mem_op_i, input, 4 bits: 0000 none, 0001 LB, 0010 LBU, 0011 LH, 0100 LHU, 0101 LW, 0110 SB, 0111 SH, 1000 SW; other codes are treated as none.
REQ-009 The module SHALL have ports mem_addr_i (input, ADDR_W) and mem_sdata_i (input, 32), the effective address and the store data.
REQ-010 The module SHALL have ports d_req_o, d_we_o (output, 1 each), d_addr_o (output, ADDR_W), d_sel_o (output, 4), d_wdata_o (output, 32), d_rdata_i (input, 32) and d_ack_i (input, 1), forming the data-bus handshake.
REQ-011 The module SHALL have port stallreq_o, output, 1 bit, meaning upstream must hold its inputs.
REQ-012 The module SHALL have ports valid_o, wreg_o (output, 1 each), wd_o (output, REG_ADDR_W) and wdata_o (output, 32), the registered results to WB.
REQ-013 The module SHALL have ports bus_err_o and align_exc_o, output, 1 bit each, each a one-cycle error pulse.

Function
REQ-014 The block SHALL implement a two-state FSM with states IDLE and WAIT.
REQ-015 In IDLE with valid_i=1 and a none op, the block SHALL register wd_i, wreg_i and wdata_i to the outputs with valid_o=1 on the next edge (latency 1) and keep stallreq_o=0.
REQ-016 In IDLE with valid_i=1 and a load or store op, the block SHALL assert stallreq_o combinationally, latch the request, and on the next edge enter WAIT with d_req_o=1.
REQ-017 In WAIT, the block SHALL hold d_req_o, d_we_o, d_addr_o, d_sel_o and d_wdata_o stable, and SHALL assert stallreq_o in every cycle except the cycle in which d_ack_i=1.
REQ-018 For byte-lane steering (little-endian, lane = addr[1:0]), d_sel_o SHALL be 0001<<lane for byte ops, 0011 or 1100 for halfword ops, and 1111 for word ops.
REQ-019 d_wdata_o SHALL carry the store byte replicated ×4 for SB, the store halfword replicated ×2 for SH, and the full word for SW.
REQ-020 Loads SHALL extract the selected byte or halfword from d_rdata_i, sign-extending for LB/LH and zero-extending for LBU/LHU.
REQ-021 In WAIT with d_ack_i=1, the block SHALL drive wdata_o as the extended load data (loads) or the latched wdata (stores), with valid_o=1, d_req_o=0 and state IDLE, all on the next edge.
REQ-022 d_ack_i SHALL be ignored outside WAIT.
REQ-023 A WAIT-cycle counter SHALL count from 0. When it reaches TIMEOUT_CYC with no ack, the block SHALL drop d_req_o, pulse bus_err_o, emit valid_o=1 with wreg_o=0, and return to IDLE.
REQ-024 If ack and timeout occur in the same cycle, ack SHALL win.
REQ-025 When no result completes in a cycle, valid_o and wreg_o SHALL be 0 on the next edge, and wd_o/wdata_o SHALL hold their values.

Reset
REQ-026 With rst=0, regardless of clk, the block SHALL set the state to IDLE, the counter to 0, and d_req_o, d_we_o, valid_o, wreg_o, bus_err_o, align_exc_o and stallreq_o to 0, and d_sel_o, d_addr_o, d_wdata_o, wd_o and wdata_o to all zeros.
REQ-027 A reset asserted during WAIT SHALL abandon the transaction with no completion output.

Configuration
REQ-028 With MEM_ALIGN_CHECK_EN defined, LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]≠00 SHALL issue no bus request, pulse align_exc_o, and emit valid_o=1 with wreg_o=0 on the next edge.
REQ-029 Without MEM_ALIGN_CHECK_EN, align_exc_o SHALL be tied 0, and the block SHALL ignore misaligned low address bits for halfword/word ops (addr[0], or addr[1:0], forced to 0).

Verification
REQ-030 The bench SHALL cover: none op, wdata_i=0x12345678, wd_i=3, wreg_i=1 -> next cycle valid_o=1, wd_o=3, wdata_o=0x12345678, stallreq_o=0.
REQ-031 The bench SHALL cover: LB at addr 0x103, rdata=0x80FFFFFF with ack after 2 WAIT cycles -> d_sel_o=1000, wdata_o=0xFFFFFF80, stallreq_o high for 3 cycles.
REQ-032 The bench SHALL cover: SH at addr 0x202, sdata=0x0000BEEF -> d_we_o=1, d_sel_o=1100, d_wdata_o=0xBEEFBEEF, wreg_o=0.
REQ-033 The bench SHALL cover: LW with TIMEOUT_CYC=4 and no ack -> d_req_o drops after 4 WAIT cycles, bus_err_o=1 for one cycle, valid_o=1, wreg_o=0.
REQ-034 The bench SHALL cover: LW at addr 0x101 with MEM_ALIGN_CHECK_EN -> d_req_o stays 0 and align_exc_o pulses; without the macro -> d_addr_o=0x100.
REQ-035 The bench SHALL cover: rst=0 during WAIT -> d_req_o=0 immediately and no valid_o after release.
